// File: rtl/button_cond_pkg.sv
// Shared state encoding and 10 MHz default timing for the button conditioner.
package button_cond_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t ARMING    = 3'd1;
  localparam state_t HELD      = 3'd2;
  localparam state_t REPEAT    = 3'd3;
  localparam state_t RELEASING = 3'd4;

  localparam int DEBOUNCE_VAL_10MHZ  = 20_000;     // 2 ms
  localparam int HOLD_DELAY_10MHZ    = 5_000_000;  // 0.5 s
  localparam int REPEAT_PERIOD_10MHZ = 2_000_000;  // 0.2 s

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, press/release debounce FSM, optional auto-repeat.
// Outputs are registered alongside the state transition that produces them.
module button_channel
  import button_cond_pkg::*;
#(
  parameter int DEBOUNCE_VAL  = DEBOUNCE_VAL_10MHZ,
  parameter int CNT_W         = 16,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int HOLD_DELAY    = HOLD_DELAY_10MHZ,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_10MHZ,
  parameter int HOLD_W        = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse,
  output logic o_release
);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_VAL - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_DELAY - 1);
  localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(REPEAT_PERIOD - 1);

  logic [1:0]        r_sync;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [HOLD_W-1:0] r_hcnt;
  logic [HOLD_W-1:0] w_hcnt_nxt;
  logic              r_level;
  logic              r_pulse;
  logic              r_release;
  logic              w_level_nxt;
  logic              w_pulse_nxt;
  logic              w_release_nxt;
  logic              w_s;

  assign w_s = r_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_level   <= 1'b0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_level   <= w_level_nxt;
      r_pulse   <= w_pulse_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hcnt_nxt  = r_hcnt;
    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = ARMING;
          w_cnt_nxt   = '0;
        end
      end
      ARMING: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_hcnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nxt = RELEASING;
          w_cnt_nxt   = '0;
        end else if (r_hcnt == HOLD_LAST) begin
          // Without auto-repeat the hold counter simply parks here.
          if (REPEAT_EN) begin
            w_state_nxt = REPEAT;
            w_hcnt_nxt  = '0;
          end
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!w_s) begin
          w_state_nxt = RELEASING;
          w_cnt_nxt   = '0;
        end else if (r_hcnt == RPT_LAST) begin
          w_hcnt_nxt = '0;
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      RELEASING: begin
        if (w_s) begin
          w_state_nxt = HELD;
          w_hcnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_hcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_pulse_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      ARMING:    w_pulse_nxt   = w_s && (r_cnt == CNT_LAST);
      HELD:      w_pulse_nxt   = REPEAT_EN && w_s && (r_hcnt == HOLD_LAST);
      REPEAT:    w_pulse_nxt   = w_s && (r_hcnt == RPT_LAST);
      RELEASING: w_release_nxt = !w_s && (r_cnt == CNT_LAST);
      default:   ;
    endcase
    w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == REPEAT) ||
                  (w_state_nxt == RELEASING);
  end

  assign o_level   = r_level;
  assign o_pulse   = r_pulse;
  assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Bank of independent button conditioners; pulse[0..3] feed anim inc/dec and speed inc/dec.
module button_conditioner
  import button_cond_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int DEBOUNCE_VAL  = DEBOUNCE_VAL_10MHZ,
  parameter int CNT_W         = 16,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int HOLD_DELAY    = HOLD_DELAY_10MHZ,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_10MHZ,
  parameter int HOLD_W        = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] i_btn_in,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_pulse,
  output logic [N_BTN-1:0] o_btn_release
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_VAL  (DEBOUNCE_VAL),
      .CNT_W         (CNT_W),
      .REPEAT_EN     (REPEAT_EN),
      .HOLD_DELAY    (HOLD_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .HOLD_W        (HOLD_W)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_btn     (i_btn_in[g]),
      .o_level   (o_btn_level[g]),
      .o_pulse   (o_btn_pulse[g]),
      .o_release (o_btn_release[g])
    );
  end

endmodule
